conv_deint_bram: RTL and testbench
==================================

CONV_DEINT_BRAM -- requirements
Module: conv_deint_bram

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and sys_rst as elsewhere in the codebase.
REQ-002 Parameter BRANCHES, default 36, SHALL set the number of commutator branches (2..64).
REQ-003 Parameter DELAY, default 2048, SHALL set the per-branch delay unit in branch writes (1..4096).
REQ-004 Parameter DATA_W, default 8, SHALL set the soft-symbol width (signed).
REQ-005 Parameter FILL, default 0, SHALL set the value emitted for not-yet-filled delay-line slots.
REQ-006 clk  input  1  rising-edge clock for all logic.
REQ-007 sys_rst  input  1  asynchronous, active-high reset.
REQ-008 in_data  input  DATA_W  soft symbol.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_first  input  1  beat is first symbol after a frame sync (commutator alignment).
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 out_data  output  DATA_W  deinterleaved symbol.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 primed  output  1  all delay lines have been filled once since reset/realign.
REQ-016 branch_idx  output  $clog2(BRANCHES)  branch the next accepted beat is routed to.

Function
REQ-017 A beat SHALL be accepted when in_valid && in_ready; out beat transfers when out_valid && out_ready.
REQ-018 Accepted beat routing: branch b = branch_idx; branch_idx increments after each accepted beat and wraps from BRANCHES-1 to 0.
REQ-019 Branch b SHALL be a FIFO of depth (BRANCHES-1-b)*DELAY; branch BRANCHES-1 has zero delay (passes the input through).
REQ-020 Output for each accepted beat SHALL be the value written to the same branch exactly (BRANCHES-1-b)*DELAY branch writes earlier, or FILL if that write never occurred.
REQ-021 Storage SHALL be one inferred single-clock RAM of BRANCHES*(BRANCHES-1)*DELAY/2 words, holding per-branch base address and wrapping pointer; read-before-write on the same address.
REQ-022 Pipeline: two stages (RAM access, output register); latency from acceptance to out_valid SHALL be exactly 2 cycles when unstalled; throughput one beat per cycle.
REQ-023 in_ready SHALL equal out_ready || !stage1_valid || !out_valid (stall-free when the output is consumed); no beat is dropped or duplicated under any out_ready pattern.
REQ-024 Output ordering SHALL equal input acceptance order.
REQ-025 primed SHALL assert on the cycle after the (BRANCHES-1)*DELAY*BRANCHES-th accepted beat and stay high until reset or realignment.
REQ-026 FILL tracking SHALL use a per-branch fill counter saturating at branch depth, not RAM initialisation.
REQ-027 in_valid low SHALL not advance branch_idx, pointers or fill counters.

Reset
REQ-028 On sys_rst: out_valid=0, out_data=0, in_ready=0, primed=0, branch_idx=0, all pointers and fill counters 0; pipeline contents discarded.
REQ-029 in_ready SHALL rise on the first clk edge after sys_rst deasserts; RAM contents need not be cleared.
REQ-030 Reset asserted mid-stream SHALL take effect immediately (asynchronously) on all outputs above.

Configuration
REQ-031 With DEINT_SYNC_ALIGN_EN defined: a beat accepted with in_first=1 SHALL be routed to branch 0, clear all fill counters and primed, and branch_idx continues from 1; data already in the pipeline completes unchanged.
REQ-032 Without DEINT_SYNC_ALIGN_EN: in_first SHALL be ignored; port remains present.

Verification (BRANCHES=4, DELAY=2, FILL=0, input values 1,2,3,...)
REQ-033 Continuous stream, out_ready=1 -> beat n=3 (value 4) emerges unchanged 2 cycles after acceptance; beats 0..2 output 0.
REQ-034 Same stream -> value 1 (branch 0) emerges as output of beat 24; value 2 (branch 1) as output of beat 17; primed rises after beat 24.
REQ-035 out_ready toggling 1 cycle on / 2 off -> output sequence identical to REQ-033/034; in_ready low only while output stalled.
REQ-036 sys_rst pulsed after beat 10 -> out_valid=0 immediately; restarting stream reproduces REQ-033 from beat 0.
REQ-037 DEINT_SYNC_ALIGN_EN, in_first=1 on beat 6 -> that beat routes to branch 0, primed=0, subsequent outputs match a fresh stream starting at beat 6.
REQ-038 in_valid gaps of random length -> outputs identical to the gap-free stream; branch_idx never advances on a gap.

Source files
------------

// File: rtl/conv_deint_bram.sv
`timescale 1ns/1ps
// conv_deint_bram: convolutional deinterleaver. Each accepted beat is routed to
// a commutator branch b whose delay line holds (BRANCHES-1-b)*DELAY words. All
// delay lines share one inferred single-port RAM. A two-stage pipeline (RAM
// access, output register) gives ready/valid flow control on both sides.
// Optional feature: define DEINT_SYNC_ALIGN_EN to realign the commutator on
// in_first.
module conv_deint_bram #(
  parameter int                BRANCHES = 36,
  parameter int                DELAY    = 2048,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] FILL     = '0
) (
  input  logic                        clk,
  input  logic                        sys_rst,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_first,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        primed,
  output logic [$clog2(BRANCHES)-1:0] branch_idx
);

  localparam int BW          = $clog2(BRANCHES);
  localparam int MAXD        = (BRANCHES - 1) * DELAY;
  localparam int RAM_WORDS   = BRANCHES * (BRANCHES - 1) * DELAY / 2;
  localparam int AW          = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW          = $clog2(MAXD + 1);
  localparam int PRIME_BEATS = MAXD * BRANCHES;
  localparam int CW          = $clog2(PRIME_BEATS + 1);

  // Per-branch constant tables: delay-line depth and RAM base address.
  logic [PW-1:0] depth_tab [BRANCHES];
  logic [AW-1:0] base_tab  [BRANCHES];

  for (genvar g = 0; g < BRANCHES; g++) begin : g_tab
    assign depth_tab[g] = PW'((BRANCHES - 1 - g) * DELAY);
    assign base_tab[g]  = AW'(DELAY * (g * (BRANCHES - 1) - (g * (g - 1)) / 2));
  end

  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic [DATA_W-1:0] rd_q;

  logic [PW-1:0] ptr      [BRANCHES];
  logic [PW-1:0] fill_cnt [BRANCHES];
  logic [CW-1:0] beat_cnt;
  logic          rdy_en;

  logic              s1_valid;
  logic              s1_fill;
  logic              s1_pass;
  logic [DATA_W-1:0] s1_din;

  logic          accept;
  logic          adv_out;
  logic          realign;
  logic [BW-1:0] sel;
  logic          sel_pass;
  logic [PW-1:0] sel_ptr;
  logic [PW-1:0] sel_depth;
  logic [PW-1:0] sel_fill_cnt;
  logic [AW-1:0] ram_addr;
  logic          ram_we;

  assign adv_out  = !out_valid || out_ready;
  assign in_ready = rdy_en && (out_ready || !s1_valid || !out_valid);
  assign accept   = in_valid && in_ready;
  assign primed   = (beat_cnt == CW'(PRIME_BEATS));

`ifndef DEINT_SYNC_ALIGN_EN
  logic unused_first;
  assign unused_first = in_first;
`endif

  // Branch selection, RAM address and write enable for the offered beat.
  always_comb begin
    sel     = branch_idx;
    realign = 1'b0;
`ifdef DEINT_SYNC_ALIGN_EN
    if (in_first) sel = '0;
    realign = accept && in_first;
`endif
    sel_pass     = (sel == BW'(BRANCHES - 1));
    sel_ptr      = ptr[sel];
    sel_depth    = depth_tab[sel];
    sel_fill_cnt = fill_cnt[sel];
    ram_addr     = sel_pass ? '0 : base_tab[sel] + AW'(sel_ptr);
    ram_we       = accept && !sel_pass;
  end

  // Shared delay-line RAM: read-before-write, read data held while stalled.
  always_ff @(posedge clk) begin
    if (accept) rd_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= in_data;
  end

  // Commutator, per-branch pointers, fill counters and priming counter.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rdy_en     <= 1'b0;
      branch_idx <= '0;
      beat_cnt   <= '0;
      for (int unsigned i = 0; i < BRANCHES; i++) begin
        ptr[i]      <= '0;
        fill_cnt[i] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        branch_idx <= sel_pass ? '0 : sel + BW'(1);
        if (!sel_pass) ptr[sel] <= (sel_ptr + PW'(1) == sel_depth) ? '0 : sel_ptr + PW'(1);
        if (realign) begin
          for (int unsigned i = 0; i < BRANCHES; i++) fill_cnt[i] <= '0;
          fill_cnt[0] <= PW'(1);
          beat_cnt    <= CW'(1);
        end else begin
          if (!sel_pass && sel_fill_cnt != sel_depth) fill_cnt[sel] <= sel_fill_cnt + PW'(1);
          if (!primed) beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

  // Two-stage pipeline: RAM access stage, then output register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_valid  <= 1'b0;
      s1_fill   <= 1'b0;
      s1_pass   <= 1'b0;
      s1_din    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (adv_out) begin
        out_valid <= s1_valid;
        if (s1_valid) out_data <= s1_fill ? FILL : (s1_pass ? s1_din : rd_q);
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_fill  <= !sel_pass && (realign || sel_fill_cnt != sel_depth);
        s1_pass  <= sel_pass;
        s1_din   <= in_data;
      end else if (adv_out) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_deint_bram.sv
`timescale 1ns/1ps
// tb_conv_deint_bram: directed bench for the deinterleaver at BRANCHES=4,
// DELAY=2, FILL=0 with input values 1,2,3,...
module tb_conv_deint_bram;

  localparam int BR = 4;
  localparam int DL = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_first = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          primed;
  logic [1:0]    branch_idx;

  always #5 clk = ~clk;

  conv_deint_bram #(
    .BRANCHES(BR),
    .DELAY   (DL),
    .DATA_W  (DW),
    .FILL    (8'd0)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .primed    (primed),
    .branch_idx(branch_idx)
  );

  int n_chk = 0;
  int n_pass = 0;
  int acc_cnt, out_cnt, cyc, first_at, viol_rdy, viol_idx;
  logic [DW-1:0] got [64];
  int            got_step [64];
  int            acc_step [64];
  logic          prim_at [64];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Expected output of the n-th accepted beat (value n+1 was written).
  function automatic int exp_val(input int n);
    int base, m, b, d, src;
    base = (first_at >= 0 && n >= first_at) ? first_at : 0;
    m    = n - base;
    b    = m % BR;
    d    = (BR - 1 - b) * DL;
    src  = m - BR * d;
    return (src < 0) ? 0 : base + src + 1;
  endfunction

  function automatic int exp_idx(input int n);
    if (first_at >= 0 && n > first_at) return (n - first_at) % BR;
    return n % BR;
  endfunction

  task automatic step(input bit rdy, input bit vld);
    @(negedge clk);
    out_ready = rdy;
    in_valid  = vld;
    in_data   = DW'(acc_cnt + 1);
    in_first  = (acc_cnt == first_at);
    #1;
    if (acc_cnt < 64) prim_at[acc_cnt] = primed;
    if (int'(branch_idx) != exp_idx(acc_cnt)) viol_idx++;
    if (!in_ready && !(out_valid && !out_ready)) viol_rdy++;
    if (out_valid && out_ready && out_cnt < 64) begin
      got[out_cnt] = out_data;
      got_step[out_cnt] = cyc;
      out_cnt++;
    end
    if (in_valid && in_ready && acc_cnt < 64) begin
      acc_step[acc_cnt] = cyc;
      acc_cnt++;
    end
    cyc++;
  endtask

  // mode 0: continuous; 1: out_ready 1 on / 2 off; 2: random in_valid gaps
  task automatic run(input int n, input int mode);
    int guard;
    int gap;
    bit vld;
    guard = 0; gap = 0;
    acc_cnt = 0; out_cnt = 0; cyc = 0; viol_rdy = 0; viol_idx = 0;
    while (out_cnt < n && guard < 1000) begin
      if (acc_cnt >= n) vld = 1'b0;
      else if (mode == 2 && gap > 0) begin
        vld = 1'b0;
        gap--;
      end else begin
        vld = 1'b1;
        if (mode == 2 && $urandom_range(0, 2) == 0) gap = $urandom_range(1, 5);
      end
      step((mode == 1) ? (cyc % 3 == 0) : 1'b1, vld);
      guard++;
    end
    check("drain", out_cnt, n);
  endtask

  task automatic verify(input int n);
    for (int i = 0; i < n; i++) check($sformatf("seq%0d", i), got[i], exp_val(i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst  = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int guard;
    first_at = -1;

    // Reset state and first ready edge
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_primed", primed, 0);
    check("rst_branch_idx", branch_idx, 0);
    @(negedge clk);
    sys_rst = 1'b0;
    #1;
    check("rdy_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("rdy_after_edge", in_ready, 1);

    // Continuous stream
    run(30, 0);
    verify(30);
    check("beat0_out", got[0], 0);
    check("beat3_out", got[3], 4);
    check("beat3_latency", got_step[3] - acc_step[3], 2);
    check("beat29_latency", got_step[29] - acc_step[29], 2);
    check("beat17_out", got[17], 2);
    check("beat24_out", got[24], 1);
    check("primed_after23", prim_at[23], 0);
    check("primed_after24", prim_at[24], 1);
    check("primed_hold", prim_at[30], 1);
    check("cont_rdy_viol", viol_rdy, 0);
    check("cont_idx_viol", viol_idx, 0);

    // Output back-pressure 1 on / 2 off
    do_reset();
    run(30, 1);
    verify(30);
    check("stall_rdy_viol", viol_rdy, 0);
    check("stall_idx_viol", viol_idx, 0);

    // Random input gaps
    do_reset();
    run(30, 2);
    verify(30);
    check("gap_idx_viol", viol_idx, 0);
    check("gap_primed", prim_at[30], 1);

    // Reset mid-stream after beat 10
    do_reset();
    acc_cnt = 0; out_cnt = 0; cyc = 0; viol_rdy = 0; viol_idx = 0;
    guard = 0;
    while (acc_cnt < 11 && guard < 100) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("mid_reach", acc_cnt, 11);
    @(posedge clk);
    #2;
    check("mid_pre_valid", out_valid, 1);
    sys_rst  = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_branch_idx", branch_idx, 0);
    @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk);
    run(30, 0);
    verify(30);
    check("mid_idx_viol", viol_idx, 0);

`ifdef DEINT_SYNC_ALIGN_EN
    // Commutator realignment on beat 6
    do_reset();
    first_at = 6;
    run(36, 0);
    verify(36);
    check("align_primed_after", prim_at[7], 0);
    check("align_primed_29", prim_at[29], 0);
    check("align_primed_30", prim_at[30], 1);
    check("align_idx_viol", viol_idx, 0);
    first_at = -1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
